// File: rtl/sample_dispatcher_pkg.sv
// Shared defaults, assembler state encoding and byte-joining helper for the
// sample dispatcher.
package sample_dispatcher_pkg;

    localparam int NUM_UNITS_DEF      = 4;
    localparam int DATA_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int BYTE_W             = 8;

    typedef enum logic [0:0] {
        ASM_IDLE     = 1'b0,
        ASM_WAIT_LSB = 1'b1
    } asm_state_e;

    // Samples arrive MSB first; the second byte lands in the low half.
    function automatic logic [2*BYTE_W-1:0] sample_join(
        input logic [BYTE_W-1:0] msb,
        input logic [BYTE_W-1:0] lsb
    );
        sample_join = {msb, lsb};
    endfunction

endpackage

// File: rtl/sample_dispatcher_byte_assembler.sv
// Byte assembler: rising-edge byte detection, MSB/LSB pairing FSM and the
// LSB timeout that discards an orphaned MSB.
module byte_assembler
    import sample_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic                  sample_done,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    asm_state_e          state_r;
    logic                bv_q_r;
    logic                armed_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [BYTE_W-1:0]   msb_r;
    logic                frame_err_r;
    logic                edge_s;

    // armed_r masks the first edge after reset so a level already high at
    // release is only counted once it falls and rises again.
    assign edge_s      = byte_valid & ~bv_q_r & armed_r;
    assign sample_done = edge_s & (state_r == ASM_WAIT_LSB) & ~flush;
    assign sample_data = DATA_WIDTH'(sample_join(msb_r, byte_in));
    assign frame_err   = frame_err_r;

    // Edge history, pairing FSM and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ASM_IDLE;
            bv_q_r      <= 1'b0;
            armed_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            msb_r       <= {BYTE_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            bv_q_r      <= byte_valid;
            armed_r     <= 1'b1;
            frame_err_r <= 1'b0;
            if (flush) begin
                state_r <= ASM_IDLE;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ASM_IDLE: begin
                        if (edge_s) begin
                            msb_r   <= byte_in;
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ASM_WAIT_LSB;
                        end else begin
                            state_r <= ASM_IDLE;
                        end
                    end
                    ASM_WAIT_LSB: begin
                        // A late LSB beats the timeout on the same edge.
                        if (edge_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ASM_IDLE;
                        end else if (cnt_r == CNT_LAST) begin
                            cnt_r       <= {CNT_W{1'b0}};
                            frame_err_r <= 1'b1;
                            state_r     <= ASM_IDLE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ASM_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sample_dispatcher.sv
// Sample dispatcher: assembles byte pairs into samples and hands each one to
// the next processing unit in round-robin order with a valid/ready handshake.
module sample_dispatcher
    import sample_dispatcher_pkg::*;
#(
    parameter int NUM_UNITS      = NUM_UNITS_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int PTR_W         = $clog2(NUM_UNITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  flush,
    input  logic [NUM_UNITS-1:0]  unit_ready,
    output logic [NUM_UNITS-1:0]  unit_valid,
    output logic [DATA_WIDTH-1:0] unit_data,
    output logic [PTR_W-1:0]      ch_ptr,
    output logic                  overflow,
    output logic                  frame_err
);

    logic                  sample_done_s;
    logic [DATA_WIDTH-1:0] sample_data_s;

    logic                  pending_r;
    logic [PTR_W-1:0]      ptr_r;
    logic [NUM_UNITS-1:0]  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  overflow_r;

    logic                  xfer_s;
    logic                  pend_nxt_s;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic [NUM_UNITS-1:0]  valid_nxt_s;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic                  ovf_nxt_s;

    byte_assembler #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .sample_done (sample_done_s),
        .sample_data (sample_data_s),
        .frame_err   (frame_err)
    );

    // Next handshake state: a transfer frees the slot before a completing
    // sample is considered, so both may happen on one edge; flush wins.
    always_comb begin
        xfer_s      = pending_r & unit_ready[ptr_r];
        pend_nxt_s  = pending_r;
        ptr_nxt_s   = ptr_r;
        data_nxt_s  = data_r;
        ovf_nxt_s   = overflow_r;
        valid_nxt_s = {NUM_UNITS{1'b0}};
        if (xfer_s) begin
            pend_nxt_s = 1'b0;
            ptr_nxt_s  = ptr_r + PTR_W'(1);
        end else begin
            pend_nxt_s = pending_r;
        end
        if (sample_done_s) begin
            if (pend_nxt_s) begin
                ovf_nxt_s = 1'b1;
            end else begin
                pend_nxt_s = 1'b1;
                data_nxt_s = sample_data_s;
            end
        end else begin
            ovf_nxt_s = overflow_r | 1'b0;
        end
        if (flush) begin
            pend_nxt_s = 1'b0;
            ptr_nxt_s  = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = ptr_nxt_s;
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            valid_nxt_s[i] = pend_nxt_s & (ptr_nxt_s == PTR_W'(i));
        end
    end

    // Handshake and pointer registers; overflow only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= 1'b0;
            ptr_r      <= {PTR_W{1'b0}};
            valid_r    <= {NUM_UNITS{1'b0}};
            data_r     <= {DATA_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pend_nxt_s;
            ptr_r      <= ptr_nxt_s;
            valid_r    <= valid_nxt_s;
            data_r     <= data_nxt_s;
            overflow_r <= ovf_nxt_s;
        end
    end

    assign unit_valid = valid_r;
    assign unit_data  = data_r;
    assign ch_ptr     = ptr_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_sample_dispatcher.sv
// Directed bench for sample_dispatcher: byte pairing, round-robin handshake,
// overflow, timeout, flush and reset behaviour with hand-computed values.
module tb_sample_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        flush;
    logic [3:0]  unit_ready;
    logic [3:0]  unit_valid;
    logic [15:0] unit_data;
    logic [1:0]  ch_ptr;
    logic        overflow;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    sample_dispatcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .flush      (flush),
        .unit_ready (unit_ready),
        .unit_valid (unit_valid),
        .unit_data  (unit_data),
        .ch_ptr     (ch_ptr),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is captured on the next rising edge
    // and the task returns at the falling edge just after it.
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] m, input logic [7:0] l);
        send_byte(m);
        @(negedge clk);
        send_byte(l);
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        flush      = 1'b0;
        unit_ready = 4'b0000;
        #3;
        check("rst_valid", unit_valid, 4'b0000);
        check("rst_data", unit_data, 16'h0000);
        check("rst_ptr", ch_ptr, 2'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sample, delivered to unit 0 and taken immediately.
        unit_ready = 4'b1111;
        send_sample(8'h12, 8'h34);
        check("basic_valid", unit_valid, 4'b0001);
        check("basic_data", unit_data, 16'h1234);
        @(negedge clk);
        check("basic_valid_clr", unit_valid, 4'b0000);
        check("basic_ptr", ch_ptr, 2'd1);

        // Flush pointer, then eight samples round-robin.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ptr", ch_ptr, 2'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send_sample(8'h00, 8'(i));
            check($sformatf("rr_valid%0d", i), unit_valid, 32'(4'b0001 << (i % 4)));
            check($sformatf("rr_data%0d", i), unit_data, 32'(i));
        end
        @(negedge clk);
        check("rr_ptr_wrap", ch_ptr, 2'd0);
        check("rr_ovf", overflow, 1'b0);
        check("rr_idle", unit_valid, 4'b0000);

        // Transfer and new LSB on the same edge; MSB accepted while pending.
        unit_ready = 4'b0000;
        send_sample(8'h11, 8'h22);
        check("co_first_valid", unit_valid, 4'b0001);
        @(negedge clk);
        send_byte(8'h33);
        check("co_hold_valid", unit_valid, 4'b0001);
        check("co_hold_data", unit_data, 16'h1122);
        @(negedge clk);
        byte_in    = 8'h44;
        byte_valid = 1'b1;
        unit_ready = 4'b1111;
        @(negedge clk);
        byte_valid = 1'b0;
        check("co_second_valid", unit_valid, 4'b0010);
        check("co_second_data", unit_data, 16'h3344);
        check("co_ptr", ch_ptr, 2'd1);
        check("co_ovf", overflow, 1'b0);
        @(negedge clk);

        // Flush while a sample is pending.
        unit_ready = 4'b0000;
        send_sample(8'h99, 8'h88);
        check("fl_pend_valid", unit_valid, 4'b0100);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_valid", unit_valid, 4'b0000);
        check("fl_ptr", ch_ptr, 2'd0);
        @(negedge clk);

        // Overflow: second sample dropped, first survives.
        send_sample(8'hAA, 8'hAA);
        check("ov_first", unit_data, 16'hAAAA);
        @(negedge clk);
        send_sample(8'hBB, 8'hBB);
        check("ov_data", unit_data, 16'hAAAA);
        check("ov_flag", overflow, 1'b1);
        check("ov_valid", unit_valid, 4'b0001);
        unit_ready = 4'b1110;
        repeat (2) @(negedge clk);
        check("ov_other_ready", unit_valid, 4'b0001);
        unit_ready = 4'b1111;
        @(negedge clk);
        check("ov_xfer_valid", unit_valid, 4'b0000);
        check("ov_xfer_ptr", ch_ptr, 2'd1);
        check("ov_xfer_data", unit_data, 16'hAAAA);
        repeat (3) @(negedge clk);
        check("ov_no_bbbb", unit_valid, 4'b0000);

        // LSB timeout after 255 idle cycles.
        send_byte(8'h55);
        repeat (254) @(negedge clk);
        check("to_early", frame_err, 1'b0);
        @(negedge clk);
        check("to_pulse", frame_err, 1'b1);
        @(negedge clk);
        check("to_pulse_end", frame_err, 1'b0);
        send_sample(8'h01, 8'h02);
        check("to_next_data", unit_data, 16'h0102);
        check("to_next_valid", unit_valid, 4'b0010);
        @(negedge clk);

        // LSB arriving on the timeout edge wins.
        send_byte(8'h66);
        repeat (254) @(negedge clk);
        send_byte(8'h77);
        check("lw_ferr", frame_err, 1'b0);
        check("lw_data", unit_data, 16'h6677);
        check("lw_valid", unit_valid, 4'b0100);
        @(negedge clk);

        // byte_valid held high for ten cycles is a single byte.
        byte_in    = 8'hC3;
        byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check("hold_no_sample", unit_valid, 4'b0000);
        @(negedge clk);
        send_byte(8'h3C);
        check("hold_data", unit_data, 16'hC33C);
        check("hold_valid", unit_valid, 4'b1000);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT_LSB with a pending sample.
        unit_ready = 4'b0000;
        send_sample(8'hDE, 8'hAD);
        check("ar_pend", unit_valid, 4'b0001);
        @(negedge clk);
        send_byte(8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", unit_valid, 4'b0000);
        check("ar_data", unit_data, 16'h0000);
        check("ar_ptr", ch_ptr, 2'd0);
        check("ar_ovf", overflow, 1'b0);
        check("ar_ferr", frame_err, 1'b0);

        // byte_valid already high at reset release must not count as a byte.
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        send_byte(8'h12);
        check("rel_no_sample", unit_valid, 4'b0000);
        @(negedge clk);
        send_byte(8'h56);
        check("rel_data", unit_data, 16'h1256);
        check("rel_valid", unit_valid, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_dispatcher.md
SAMPLE_DISPATCHER -- requirements
Module: sample_dispatcher

Interface
REQ-001 Parameter NUM_UNITS, default 4, is the number of processing units served; it SHALL be a power of two, 2..8.
REQ-002 Parameter DATA_WIDTH, default 16, is the sample width, assembled as two 8-bit bytes, MSB first.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, is the maximum wait, in cycles, for an LSB after its MSB.
REQ-004 Ports SHALL be: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 byte_valid  in  1  byte strobe; a rising edge marks one new byte.
REQ-006 byte_in  in  8  data byte, sampled on the byte_valid rising edge.
REQ-007 flush  in  1  synchronous clear of assembly state, pending sample and pointer.
REQ-008 unit_ready  in  NUM_UNITS  per-unit ready to accept a sample.
REQ-009 unit_valid  out  NUM_UNITS  one-hot request to the unit addressed by the pointer.
REQ-010 unit_data  out  DATA_WIDTH  assembled sample; stable while any unit_valid bit is high.
REQ-011 ch_ptr  out  log2(NUM_UNITS)  index of the next destination unit.
REQ-012 overflow  out  1  sticky flag: a sample was dropped.
REQ-013 frame_err  out  1  one-cycle pulse when an LSB timeout occurs.

Function
REQ-014 Byte edge SHALL be byte_valid & ~bv_q, where bv_q is byte_valid registered; a level held for N cycles counts as one byte.
REQ-015 Assembler FSM SHALL have states IDLE and WAIT_LSB.
REQ-016 IDLE + edge: capture byte_in as MSB, clear the timeout counter, go to WAIT_LSB.
REQ-017 WAIT_LSB + edge: form {MSB, byte_in} and go to IDLE; the sample completes on that clock edge.
REQ-018 WAIT_LSB, no edge: the counter increments; at TIMEOUT_CYCLES the FSM SHALL go to IDLE, discard the MSB and pulse frame_err for one cycle.
REQ-019 If an LSB edge and the timeout coincide, the LSB SHALL win; no frame_err is raised.
REQ-020 Completed sample, no pending sample: load unit_data; unit_valid[ch_ptr]=1 from the next cycle (latency 1 cycle after the LSB edge).
REQ-021 Completed sample, pending sample still held: the new sample SHALL be dropped and overflow set; the pending sample is unaffected.
REQ-022 Pending sample with unit_valid[ch_ptr] & unit_ready[ch_ptr] at a clock edge: the transfer occurs, unit_valid clears, ch_ptr increments modulo NUM_UNITS (NUM_UNITS-1 wraps to 0).
REQ-023 A sample completing on the same edge as a transfer SHALL be accepted, not dropped; unit_valid stays high for the new sample addressed to the incremented ch_ptr.
REQ-024 unit_ready bits of non-addressed units SHALL be ignored; unit_valid SHALL never have more than one bit set.
REQ-025 Once asserted, unit_valid SHALL NOT drop without a transfer, except on flush or reset.
REQ-026 The MSB of the next sample SHALL be accepted while a sample is pending.
REQ-027 flush=1: FSM to IDLE, pending sample dropped, unit_valid=0, ch_ptr=0, counter=0. overflow is cleared only by reset. Flush overrides a simultaneous edge or transfer.

Reset
REQ-028 With rst_n low, asynchronously: FSM=IDLE, bv_q=0, counter=0, ch_ptr=0, unit_valid=0, unit_data=0, overflow=0, frame_err=0.
REQ-029 Reset mid-sample or mid-handshake SHALL discard all state; a byte_valid already high at reset release SHALL NOT produce an edge until it falls and rises again (bv_q is loaded from byte_valid on the first clock edge).

Structure
REQ-030 A shared package SHALL hold NUM_UNITS, DATA_WIDTH, TIMEOUT_CYCLES defaults and the assembler state enum.
REQ-031 The byte assembler (edge detect, FSM, timeout) SHALL be sub-module byte_assembler; the handshake and pointer logic stay in the top level.

Verification
REQ-032 Bytes 0x12 then 0x34, unit_ready=4'b1111 -> unit_valid=4'b0001, unit_data=0x1234 one cycle after the LSB edge; ch_ptr=1 after the transfer.
REQ-033 Eight samples 0x0000..0x0007, all units ready -> units receive 0,1,2,3,0,1,2,3 in order; ch_ptr wraps 3->0; overflow=0.
REQ-034 unit_ready=0, two complete samples 0xAAAA and 0xBBBB -> unit_data holds 0xAAAA, overflow=1; after ready rises, 0xAAAA is delivered and 0xBBBB is never seen.
REQ-035 MSB 0x55 then 255 idle cycles -> frame_err pulses once, FSM IDLE; next bytes 0x01,0x02 -> sample 0x0102.
REQ-036 Transfer and new LSB on the same edge -> second sample goes to ch_ptr+1 with no overflow; flush during a pending sample -> unit_valid=0, ch_ptr=0.
REQ-037 byte_valid held high for 10 cycles -> exactly one byte captured; rst_n pulsed low mid-WAIT_LSB -> all outputs at reset values asynchronously.
